uart_cmd_slv: RTL and testbench
===============================

Name: uart_cmd_slv

Overview:
Remote-side command receiver that pairs with the command master across the serial link.
- Instantiates the team's UART transceiver.
- Assembles three received bytes (MSB first) into a 24-bit command and presents it with a ready flag to the downstream command processor.
- Transmits a single 8-bit response byte back to the master on request.
- An inter-byte timeout resynchronises framing if a byte is lost.

Parameters:
TIMEOUT_CYC, 1_000_000, clk cycles allowed between bytes of one command before the partial command is discarded (20 ms at 50 MHz).
TO_W, $clog2(TIMEOUT_CYC+1), timeout counter width (derived; not overridden).

Ports:
clk  input  1  system clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
RX  input  1  serial data from master
TX  output  1  serial data to master
cmd  output  24  last complete command, {byte1,byte2,byte3}
cmd_rdy  output  1  new complete command available in cmd
clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy
resp  input  8  response byte to transmit
send_resp  input  1  one-cycle request to transmit resp
resp_sent  output  1  set when last requested response finished shifting out

Behaviour:
Reset values:
- TX idles high (via UART).
- cmd = 24'h000000, cmd_rdy = 0, resp_sent = 0.
- RX state = RX_HI, timeout counter = 0.

Receive FSM (rx_state_t: RX_HI, RX_MID, RX_LO):
- Any state, UART rdy=1: latch rx_data; drive UART clr_rdy=1 that same cycle.
- Transitions on each byte: RX_HI -> RX_MID -> RX_LO -> RX_HI.
- Byte in RX_HI goes to hi_byte; byte in RX_MID goes to mid_byte.
- Byte in RX_LO: cmd <= {hi_byte, mid_byte, rx_data} and cmd_rdy <= 1, both visible the cycle after UART rdy (latency 1 clk).
- cmd changes only on a completed third byte. Partial commands never disturb cmd or cmd_rdy.

cmd_rdy:
- Set by command completion; cleared by clr_cmd_rdy.
- Completion and clr_cmd_rdy in the same cycle: set wins.
- A new command completing while cmd_rdy=1 overwrites cmd; cmd_rdy stays 1 (no overrun flag).

Timeout:
- Counter clears on every received byte and while in RX_HI.
- Increments each clk in RX_MID/RX_LO.
- Reaching TIMEOUT_CYC-1: FSM returns to RX_HI, counter clears, partial bytes discarded, cmd/cmd_rdy unchanged.
- A byte arriving in the same cycle as expiry is treated as a byte: it advances the FSM and does not time out.

Transmit FSM (tx_state_t: TX_IDLE, TX_BUSY):
- TX_IDLE, send_resp=1: UART trmt=1 with tx_data=resp that cycle; resp_sent <= 0; go TX_BUSY.
- TX_BUSY, tx_done=1: resp_sent <= 1; go TX_IDLE.
- send_resp during TX_BUSY is ignored (no queueing); resp_sent remains 0.
- Transmit and receive paths are fully independent and may run concurrently.

Reset mid-operation:
- Asynchronous return to reset values; partial command lost; any in-flight TX byte aborted (UART resets).

Decomposition:
Shared package uart_cmd_pkg:
- rx_state_t and tx_state_t enums.
- CMD_BYTES = 3.
- Default TIMEOUT_CYC constant.
The block instantiates the existing UART transceiver as its one sub-module; no new sub-module.

Test Plan:
1. Master sends 24'hA5_3C_0F -> cmd=24'hA53C0F and cmd_rdy=1 exactly 1 clk after third-byte UART rdy; cmd_rdy holds until clr_cmd_rdy pulse, then 0.
2. Send bytes 8'h11, 8'h22, stall > TIMEOUT_CYC, then send 24'h010203 -> cmd=24'h010203 (not 24'h112201); cmd_rdy never set during the stall.
3. clr_cmd_rdy asserted in the same cycle a second command (24'hDEADBE) completes -> cmd_rdy stays 1, cmd=24'hDEADBE.
4. send_resp with resp=8'hA5 -> TX frame carries 8'hA5; resp_sent 0 from next clk until tx_done, then 1. Second send_resp mid-frame -> no extra frame on TX.
5. Full-duplex: send_resp (8'h5A) while a 3-byte command (24'h123456) is arriving -> both complete correctly and cmd=24'h123456.
6. Assert rst_n low after the first byte of a command -> all outputs at reset values. The following full command 24'h00FF00 is received correctly.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the serial command slave.
// Holds FSM state encodings, command byte count and default timing.
package uart_cmd_pkg;

    localparam int CMD_BYTES   = 3;
    localparam int CMD_W       = 8 * CMD_BYTES;

    // 20 ms inter-byte window at 50 MHz
    localparam int TIMEOUT_DEF = 1_000_000;

    // 50 MHz / 115200 baud
    localparam int BAUD_DEF    = 434;

    typedef logic [1:0] rx_state_t;
    localparam rx_state_t RX_HI  = 2'd0;
    localparam rx_state_t RX_MID = 2'd1;
    localparam rx_state_t RX_LO  = 2'd2;

    typedef logic [0:0] tx_state_t;
    localparam tx_state_t TX_IDLE = 1'b0;
    localparam tx_state_t TX_BUSY = 1'b1;

endpackage

// File: rtl/uart.sv
// 8N1 UART transceiver, BAUD_DIV clocks per bit.
// Ports: RX/TX serial, rx_data/rdy/clr_rdy receive, tx_data/trmt/tx_done send.
module uart #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    output logic [7:0] rx_data,
    output logic       rdy,
    input  logic       clr_rdy,
    input  logic [7:0] tx_data,
    input  logic       trmt,
    output logic       tx_done
);

    localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    logic [9:0]    tx_sh;
    logic [3:0]    tx_cnt;
    logic [BW-1:0] tx_baud;
    logic          tx_busy;

    assign TX = tx_sh[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sh   <= '1;
            tx_cnt  <= '0;
            tx_baud <= '0;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (trmt) begin
                tx_sh   <= {1'b1, tx_data, 1'b0};
                tx_cnt  <= '0;
                tx_baud <= '0;
                tx_busy <= 1'b1;
            end else if (tx_busy) begin
                if (tx_baud == BW'(BAUD_DIV - 1)) begin
                    tx_baud <= '0;
                    tx_sh   <= {1'b1, tx_sh[9:1]};
                    if (tx_cnt == 4'd9) begin
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt + 4'd1;
                    end
                end else begin
                    tx_baud <= tx_baud + 1'b1;
                end
            end
        end
    end

    logic          rx_s1;
    logic          rx_s2;
    logic          rx_busy;
    logic [3:0]    rx_cnt;
    logic [BW-1:0] rx_baud;
    logic [7:0]    rx_sh;

    // Start bit edge preloads half a bit so every sample lands mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_busy <= 1'b0;
            rx_cnt  <= '0;
            rx_baud <= '0;
            rx_sh   <= '0;
            rx_data <= '0;
            rdy     <= 1'b0;
        end else begin
            rx_s1 <= RX;
            rx_s2 <= rx_s1;
            if (clr_rdy)
                rdy <= 1'b0;
            if (!rx_busy) begin
                if (!rx_s2) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= '0;
                    rx_baud <= BW'(BAUD_DIV / 2);
                end
            end else if (rx_baud == BW'(BAUD_DIV - 1)) begin
                rx_baud <= '0;
                if (rx_cnt == 4'd9) begin
                    rx_busy <= 1'b0;
                    rx_data <= rx_sh;
                    rdy     <= 1'b1;
                end else begin
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_cnt <= rx_cnt + 4'd1;
                end
            end else begin
                rx_baud <= rx_baud + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_slv.sv
// Remote command receiver: 3 bytes MSB first -> 24-bit cmd, 1-byte response.
// Ports: RX/TX serial, cmd/cmd_rdy/clr_cmd_rdy, resp/send_resp/resp_sent.
module uart_cmd_slv
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_DEF,
    parameter int BAUD_DIV    = BAUD_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             RX,
    output logic             TX,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_rdy,
    input  logic             clr_cmd_rdy,
    input  logic [7:0]       resp,
    input  logic             send_resp,
    output logic             resp_sent
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       trmt;
    logic       tx_done;

    uart #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .TX      (TX),
        .rx_data (rx_data),
        .rdy     (rx_rdy),
        .clr_rdy (rx_rdy),
        .tx_data (resp),
        .trmt    (trmt),
        .tx_done (tx_done)
    );

    rx_state_t   rx_state;
    logic [7:0]  hi_byte;
    logic [7:0]  mid_byte;
    logic [TO_W-1:0] to_cnt;
    logic        done3;

    assign done3 = rx_rdy && (rx_state == RX_LO);

    // A byte in the expiry cycle wins over the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_HI;
            hi_byte  <= '0;
            mid_byte <= '0;
            to_cnt   <= '0;
            cmd      <= '0;
        end else if (rx_rdy) begin
            to_cnt <= '0;
            unique case (rx_state)
                RX_HI: begin
                    hi_byte  <= rx_data;
                    rx_state <= RX_MID;
                end
                RX_MID: begin
                    mid_byte <= rx_data;
                    rx_state <= RX_LO;
                end
                default: begin
                    cmd      <= {hi_byte, mid_byte, rx_data};
                    rx_state <= RX_HI;
                end
            endcase
        end else if (rx_state == RX_HI) begin
            to_cnt <= '0;
        end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            to_cnt   <= '0;
            rx_state <= RX_HI;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cmd_rdy <= 1'b0;
        else if (done3)
            cmd_rdy <= 1'b1;
        else if (clr_cmd_rdy)
            cmd_rdy <= 1'b0;
    end

    tx_state_t tx_state;

    assign trmt = (tx_state == TX_IDLE) && send_resp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state  <= TX_IDLE;
            resp_sent <= 1'b0;
        end else if (trmt) begin
            tx_state  <= TX_BUSY;
            resp_sent <= 1'b0;
        end else if ((tx_state == TX_BUSY) && tx_done) begin
            tx_state  <= TX_IDLE;
            resp_sent <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_cmd_slv.sv
// Scoreboard bench for uart_cmd_slv: commands and TX frames via queues.
// Short baud and timeout keep the run small.
module tb_uart_cmd_slv;

    localparam int BAUD = 16;
    localparam int TOUT = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        TX;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        send_resp = 1'b0;
    logic        resp_sent;

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_cmd_q[$];
    logic [7:0]  exp_tx_q[$];

    always #5 clk = ~clk;

    uart_cmd_slv #(
        .TIMEOUT_CYC (TOUT),
        .BAUD_DIV    (BAUD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            RX = fr[i];
            repeat (BAUD - 1) @(negedge clk);
        end
    endtask

    task automatic send_cmd(input logic [23:0] c);
        send_byte(c[23:16]);
        send_byte(c[15:8]);
        send_byte(c[7:0]);
    endtask

    task automatic pulse_resp(input logic [7:0] r);
        @(negedge clk);
        resp = r;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
    endtask

    // Command monitor: a new cmd or rising cmd_rdy is one completion.
    logic [23:0] prev_cmd = '0;
    logic        prev_rdy = 1'b0;
    logic        prev_rxrdy = 1'b0;
    always @(negedge clk) begin
        if (rst_n && ((cmd !== prev_cmd) || (cmd_rdy && !prev_rdy))) begin
            if (exp_cmd_q.size() == 0) begin
                chk("unexpected_cmd", {8'h0, cmd}, 32'hFFFFFFFF);
            end else begin
                chk("cmd", {8'h0, cmd}, {8'h0, exp_cmd_q.pop_front()});
                chk("cmd_rdy_set", {31'h0, cmd_rdy}, 32'h1);
                chk("cmd_latency", {31'h0, prev_rxrdy}, 32'h1);
            end
        end
        prev_cmd   <= cmd;
        prev_rdy   <= cmd_rdy;
        prev_rxrdy <= dut.rx_rdy;
    end

    // TX monitor: decode 8N1 frames sampled mid-bit.
    initial begin
        logic [7:0] b;
        logic       stp;
        forever begin
            @(negedge clk);
            if (rst_n && TX === 1'b0) begin
                repeat (BAUD / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD) @(negedge clk);
                    b[i] = TX;
                end
                repeat (BAUD) @(negedge clk);
                stp = TX;
                chk("tx_stop", {31'h0, stp}, 32'h1);
                if (exp_tx_q.size() == 0)
                    chk("unexpected_tx", {24'h0, b}, 32'hFFFFFFFF);
                else
                    chk("tx_byte", {24'h0, b}, {24'h0, exp_tx_q.pop_front()});
            end
        end
    end

    task automatic wait_resp_sent(output int n);
        n = 0;
        while (resp_sent !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("resp_sent_timeout", {31'h0, resp_sent}, 32'h1);
    endtask

    initial begin
        int n;
        int hit;
        repeat (3) @(negedge clk);
        chk("rst_TX", {31'h0, TX}, 32'h1);
        chk("rst_cmd", {8'h0, cmd}, 32'h0);
        chk("rst_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
        chk("rst_resp_sent", {31'h0, resp_sent}, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        exp_cmd_q.push_back(24'hA53C0F);
        send_cmd(24'hA53C0F);
        repeat (4) @(negedge clk);
        chk("t1_rdy_hold", {31'h0, cmd_rdy}, 32'h1);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        chk("t1_rdy_clr", {31'h0, cmd_rdy}, 32'h0);

        send_byte(8'h11);
        send_byte(8'h22);
        hit = 0;
        for (int i = 0; i < TOUT + 500; i++) begin
            @(negedge clk);
            if (cmd_rdy) hit = 1;
        end
        chk("t2_stall_rdy", hit, 0);
        exp_cmd_q.push_back(24'h010203);
        send_cmd(24'h010203);
        repeat (4) @(negedge clk);
        chk("t2_cmd", {8'h0, cmd}, 32'h00010203);

        exp_cmd_q.push_back(24'hDEADBE);
        send_byte(8'hDE);
        send_byte(8'hAD);
        fork
            send_byte(8'hBE);
            begin
                n = 0;
                while (dut.rx_rdy !== 1'b1 && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                chk("t3_rx_seen", {31'h0, dut.rx_rdy}, 32'h1);
                clr_cmd_rdy = 1'b1;
                @(negedge clk);
                clr_cmd_rdy = 1'b0;
                chk("t3_set_wins", {31'h0, cmd_rdy}, 32'h1);
            end
        join
        chk("t3_cmd", {8'h0, cmd}, 32'h00DEADBE);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;

        exp_tx_q.push_back(8'hA5);
        pulse_resp(8'hA5);
        chk("t4_sent_low", {31'h0, resp_sent}, 32'h0);
        repeat (80) @(negedge clk);
        pulse_resp(8'hFF);
        chk("t4_sent_low_mid", {31'h0, resp_sent}, 32'h0);
        wait_resp_sent(n);
        n = n + 82;
        if (n < 155 || n > 170)
            chk("t4_sent_time", n, 161);
        repeat (3 * BAUD * 10) @(negedge clk);
        chk("t4_no_extra", exp_tx_q.size(), 0);

        exp_cmd_q.push_back(24'h123456);
        exp_tx_q.push_back(8'h5A);
        fork
            send_cmd(24'h123456);
            begin
                repeat (100) @(negedge clk);
                pulse_resp(8'h5A);
                wait_resp_sent(n);
            end
        join
        repeat (BAUD * 12) @(negedge clk);
        chk("t5_cmd", {8'h0, cmd}, 32'h00123456);
        chk("t5_tx_drained", exp_tx_q.size(), 0);

        send_byte(8'h77);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_TX", {31'h0, TX}, 32'h1);
        chk("t6_cmd", {8'h0, cmd}, 32'h0);
        chk("t6_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
        chk("t6_resp_sent", {31'h0, resp_sent}, 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        exp_cmd_q.push_back(24'h00FF00);
        send_cmd(24'h00FF00);
        repeat (4) @(negedge clk);
        chk("t6_cmd_after", {8'h0, cmd}, 32'h0000FF00);
        chk("t6_rdy_after", {31'h0, cmd_rdy}, 32'h1);

        repeat (20) @(negedge clk);
        chk("cmd_q_empty", exp_cmd_q.size(), 0);
        chk("tx_q_empty", exp_tx_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
